posit_batch_engine: RTL

Parametrised memory-to-memory sequencer for posit arithmetic. It fetches operands from a source on-chip RAM and streams them through an external pipelined posit unit (adder or multiplier). Results go to a destination RAM. It succeeds the fixed single-add wrapper with configurable width, address space and element count. It adds a reduction mode that accumulates a vector through the unit and in-order handling of the unit's result latency. It sits between the HPS-visible on-chip memories/PIOs and the posit arithmetic core in the SoC top.

---
 rtl/posit_batch_engine_if.sv | 40 ++++
 rtl/posit_batch_engine.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/posit_batch_engine_if.sv
// Bundle of every signal between the batch engine and its SoC neighbours:
// HPS control/status PIOs, the two on-chip RAM ports and the posit unit.
interface posit_batch_engine_if #(
  parameter int POSIT_WIDTH = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int CNT_WIDTH   = 10
);
  logic                   io_start;
  logic                   io_mode;
  logic [CNT_WIDTH-1:0]   io_count;
  logic [ADDR_WIDTH-1:0]  io_src_base;
  logic [ADDR_WIDTH-1:0]  io_dst_base;
  logic [ADDR_WIDTH-1:0]  io_rd_addr;
  logic [POSIT_WIDTH-1:0] io_rd_data;
  logic [ADDR_WIDTH-1:0]  io_wr_addr;
  logic [POSIT_WIDTH-1:0] io_wr_data;
  logic                   io_wr_en;
  logic                   io_op_valid;
  logic [POSIT_WIDTH-1:0] io_op_a;
  logic [POSIT_WIDTH-1:0] io_op_b;
  logic                   io_res_valid;
  logic [POSIT_WIDTH-1:0] io_res_data;
  logic                   io_busy;
  logic                   io_done;
  logic [POSIT_WIDTH-1:0] io_result;

  modport master (
    input  io_start, io_mode, io_count, io_src_base, io_dst_base,
           io_rd_data, io_res_valid, io_res_data,
    output io_rd_addr, io_wr_addr, io_wr_data, io_wr_en,
           io_op_valid, io_op_a, io_op_b, io_busy, io_done, io_result
  );

  modport slave (
    output io_start, io_mode, io_count, io_src_base, io_dst_base,
           io_rd_data, io_res_valid, io_res_data,
    input  io_rd_addr, io_wr_addr, io_wr_data, io_wr_en,
           io_op_valid, io_op_a, io_op_b, io_busy, io_done, io_result
  );
endinterface

// File: rtl/posit_batch_engine.sv
// Memory-to-memory sequencer that streams operand pairs (or a reduction chain)
// from a source RAM through an external pipelined posit unit into a destination RAM.
module posit_batch_engine #(
  parameter int POSIT_WIDTH = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int CNT_WIDTH   = 10
) (
  input logic                  clock,
  input logic                  reset_n,
  posit_batch_engine_if.master bus
);

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_RD_A     = 4'd1;
  localparam logic [3:0] ST_RD_B     = 4'd2;
  localparam logic [3:0] ST_ISSUE    = 4'd3;
  localparam logic [3:0] ST_DRAIN    = 4'd4;
  localparam logic [3:0] ST_LOAD     = 4'd5;
  localparam logic [3:0] ST_LOAD_CAP = 4'd6;
  localparam logic [3:0] ST_WAIT     = 4'd7;
  localparam logic [3:0] ST_WRITE    = 4'd8;

  logic [3:0]             state;
  logic                   mode_q;
  logic                   start_q;
  logic                   busy_q;
  logic                   done_q;
  logic [CNT_WIDTH-1:0]   count_q;
  logic [CNT_WIDTH-1:0]   idx;
  logic [CNT_WIDTH-1:0]   res_cnt;
  logic [CNT_WIDTH-1:0]   last_idx;
  logic [CNT_WIDTH:0]     outstanding;
  logic [ADDR_WIDTH-1:0]  src_q;
  logic [ADDR_WIDTH-1:0]  dst_q;
  logic [ADDR_WIDTH-1:0]  idx_addr;
  logic [ADDR_WIDTH-1:0]  pair_addr;
  logic [POSIT_WIDTH-1:0] a_q;
  logic [POSIT_WIDTH-1:0] acc;
  logic [POSIT_WIDTH-1:0] result_q;
  logic                   start_fire;
  logic                   issue;
  logic                   res_take;
  logic                   wr_en;
  logic                   issue_cnt;

  assign last_idx   = count_q - CNT_WIDTH'(1);
  assign idx_addr   = ADDR_WIDTH'(idx);
  assign pair_addr  = src_q + {idx_addr[ADDR_WIDTH-2:0], 1'b0};

  // Only a rising edge of start counts, so a start held high yields a single run.
  assign start_fire = (state == ST_IDLE) && bus.io_start && !start_q;
  assign issue      = (state == ST_ISSUE);
  assign issue_cnt  = issue && !mode_q;
  assign res_take   = !mode_q && (state != ST_IDLE) && bus.io_res_valid && (outstanding != '0);
  assign wr_en      = res_take || (state == ST_WRITE);

  always_comb begin
    bus.io_rd_addr = '0;
    case (state)
      ST_RD_A: bus.io_rd_addr = pair_addr;
      ST_RD_B: bus.io_rd_addr = mode_q ? (src_q + idx_addr) : (pair_addr + ADDR_WIDTH'(1));
      ST_LOAD: bus.io_rd_addr = src_q;
      default: bus.io_rd_addr = '0;
    endcase
  end

  // Write-back is purely combinational so a result is stored in the cycle it returns.
  assign bus.io_wr_en    = wr_en;
  assign bus.io_wr_addr  = !wr_en ? '0 : (mode_q ? dst_q : dst_q + ADDR_WIDTH'(res_cnt));
  assign bus.io_wr_data  = !wr_en ? '0 : (mode_q ? acc : bus.io_res_data);
  assign bus.io_op_valid = issue;
  assign bus.io_op_a     = !issue ? '0 : (mode_q ? acc : a_q);
  assign bus.io_op_b     = issue ? bus.io_rd_data : '0;
  assign bus.io_busy     = busy_q;
  assign bus.io_done     = done_q;
  assign bus.io_result   = result_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      mode_q      <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= '0;
      idx         <= '0;
      res_cnt     <= '0;
      outstanding <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      a_q         <= '0;
      acc         <= '0;
      result_q    <= '0;
    end else begin
      start_q <= bus.io_start;
      if (wr_en) result_q <= bus.io_wr_data;
      if (res_take) res_cnt <= res_cnt + CNT_WIDTH'(1);
      if (issue_cnt && !res_take) outstanding <= outstanding + (CNT_WIDTH+1)'(1);
      else if (res_take && !issue_cnt) outstanding <= outstanding - (CNT_WIDTH+1)'(1);

      case (state)
        ST_IDLE: begin
          if (start_fire) begin
            mode_q  <= bus.io_mode;
            count_q <= bus.io_count;
            src_q   <= bus.io_src_base;
            dst_q   <= bus.io_dst_base;
            idx     <= '0;
            res_cnt <= '0;
            if (bus.io_count == '0) begin
              done_q <= 1'b1;
            end else begin
              done_q <= 1'b0;
              busy_q <= 1'b1;
              state  <= bus.io_mode ? ST_LOAD : ST_RD_A;
            end
          end
        end
        ST_RD_A: state <= ST_RD_B;
        ST_RD_B: begin
          if (!mode_q) a_q <= bus.io_rd_data;
          state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (mode_q) begin
            state <= ST_WAIT;
          end else if (idx == last_idx) begin
            state <= ST_DRAIN;
          end else begin
            idx   <= idx + CNT_WIDTH'(1);
            state <= ST_RD_A;
          end
        end
        ST_DRAIN: begin
          if ((res_take && (res_cnt == last_idx)) || (res_cnt == count_q)) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        ST_LOAD: state <= ST_LOAD_CAP;
        ST_LOAD_CAP: begin
          acc <= bus.io_rd_data;
          if (count_q == CNT_WIDTH'(1)) begin
            state <= ST_WRITE;
          end else begin
            idx   <= CNT_WIDTH'(1);
            state <= ST_RD_B;
          end
        end
        ST_WAIT: begin
          if (bus.io_res_valid) begin
            acc <= bus.io_res_data;
            if (idx == last_idx) begin
              state <= ST_WRITE;
            end else begin
              idx   <= idx + CNT_WIDTH'(1);
              state <= ST_RD_B;
            end
          end
        end
        ST_WRITE: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
